// File: rtl/chaos_bit_expander.sv
// chaos_bit_expander
//   Packs N = OUT_W/IN_W chaotic-map samples into one OUT_W-bit word for the wire
//   shuffler. Two levels of buffering: the accumulator fills while the output slot
//   holds the previous word for the downstream stage.
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready upstream sample handshake (in_ready is combinational)
//   flush                     discard the word being collected in the accumulator
//   out_data/out_valid/out_ready  downstream word handshake (registered)
//   word_cnt                  number of delivered words, wraps at 2^16
module chaos_bit_expander #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 256,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      word_cnt
);

  localparam int unsigned N     = OUT_W / IN_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Output word must be an exact multiple of the sample width.
  generate
    if (((OUT_W % IN_W) != 0) || (N == 0)) begin : g_bad_width
      $error("chaos_bit_expander: OUT_W must be a non-zero multiple of IN_W");
    end
  endgenerate

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [OUT_W-1:0]   acc, acc_nxt;
  logic [OUT_W-1:0]   out_data_nxt;
  logic               out_valid_nxt;
  logic [15:0]        word_cnt_nxt;

  logic               accept;
  logic               slot_free;
  logic               out_hs;
  logic [CNT_W-1:0]   slot_idx;

  // Ready depends only on reset, flush and whether the accumulator is parked.
  assign in_ready  = !rst && !flush && (state == FILL);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign out_hs    = out_valid && out_ready;
  assign slot_idx  = LSB_FIRST ? count : (LAST - count);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      acc       <= acc_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      word_cnt  <= word_cnt_nxt;
    end
  end

  // Next-state: collect samples, hand complete words to the output slot
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    acc_nxt       = acc;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    word_cnt_nxt  = word_cnt;

    // Consumed word; a transfer below may refill the slot in the same cycle.
    if (out_hs) begin
      out_valid_nxt = 1'b0;
      word_cnt_nxt  = word_cnt + 16'd1;
    end

    if (flush) begin
      // Flush wins over a pending HOLD transfer; accumulator contents go stale.
      count_nxt = '0;
      state_nxt = FILL;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            for (int unsigned k = 0; k < N; k++) begin
              if (slot_idx == CNT_W'(k)) begin
                acc_nxt[k*IN_W +: IN_W] = in_data;
              end
            end
            if (count == LAST) begin
              count_nxt = '0;
              if (slot_free) begin
                out_data_nxt  = acc_nxt;
                out_valid_nxt = 1'b1;
              end else begin
                state_nxt = HOLD;
              end
            end else begin
              count_nxt = count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            out_data_nxt  = acc;
            out_valid_nxt = 1'b1;
            state_nxt     = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_bit_expander.sv
// Testbench for chaos_bit_expander: two instances (LSB-first and MSB-first) share the
// same stimulus; a queue/array-level model predicts readiness, words and counts.
module tb_chaos_bit_expander;

  logic         clk;
  logic         rst;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         flush;
  logic         out_ready;
  logic         in_ready,  in_ready_m;
  logic [255:0] out_data,  out_data_m;
  logic         out_valid, out_valid_m;
  logic [15:0]  word_cnt,  word_cnt_m;

  chaos_bit_expander #(.IN_W(16), .OUT_W(256), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_cnt(word_cnt)
  );

  chaos_bit_expander #(.IN_W(16), .OUT_W(256), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .flush(flush), .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .word_cnt(word_cnt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0]  m_part [16];
  int           m_n;
  logic         m_held;
  logic [255:0] m_held_l, m_held_m;
  logic         m_ov;
  logic [255:0] m_od_l, m_od_m;
  logic [15:0]  m_wc;

  logic exp_in_ready, obs_in_ready, obs_in_ready_m, last_acc;

  // One clock of stimulus; the model advances with the DUT edge.
  task automatic step(input logic r, input logic iv, input logic [15:0] d,
                      input logic fl, input logic ordy);
    logic hs, free;
    logic [255:0] w_l, w_m;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    #1;
    exp_in_ready   = !r && !fl && !m_held;
    last_acc       = iv && exp_in_ready;
    obs_in_ready   = in_ready;
    obs_in_ready_m = in_ready_m;
    @(posedge clk);
    if (r) begin
      m_n = 0; m_held = 1'b0; m_ov = 1'b0; m_od_l = '0; m_od_m = '0; m_wc = '0;
    end else begin
      hs   = m_ov && ordy;
      free = !m_ov || ordy;
      if (hs) begin m_wc = m_wc + 16'd1; m_ov = 1'b0; end
      if (fl) begin
        m_n = 0; m_held = 1'b0;
      end else if (m_held) begin
        if (free) begin m_od_l = m_held_l; m_od_m = m_held_m; m_ov = 1'b1; m_held = 1'b0; end
      end else if (last_acc) begin
        m_part[m_n] = d;
        m_n++;
        if (m_n == 16) begin
          for (int k = 0; k < 16; k++) begin
            w_l[k*16 +: 16]      = m_part[k];
            w_m[(15-k)*16 +: 16] = m_part[k];
          end
          m_n = 0;
          if (free) begin m_od_l = w_l; m_od_m = w_m; m_ov = 1'b1; end
          else begin m_held_l = w_l; m_held_m = w_m; m_held = 1'b1; end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 16'h0, 0, 0);
    step(1, 1, 16'h1234, 0, 1);
    n_cmp++; if (obs_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", obs_in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== 256'h0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (word_cnt !== 16'h0) begin n_err++; $display("FAIL reset_word_cnt got=%0d want=0", word_cnt); end
    step(0, 0, 16'h0, 0, 1);
    n_cmp++; if (obs_in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", obs_in_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 16'(i), 0, 1);
      if (i < 15) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_early_valid i=%0d got=%b want=0", i, out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_latency got=%b want=1", out_valid); end
    n_cmp++; if (out_data[15:0] !== 16'h0000) begin n_err++; $display("FAIL fill_lsb_low got=%h want=0000", out_data[15:0]); end
    n_cmp++; if (out_data[255:240] !== 16'h000F) begin n_err++; $display("FAIL fill_lsb_high got=%h want=000f", out_data[255:240]); end
    n_cmp++; if (out_data_m[255:240] !== 16'h0000) begin n_err++; $display("FAIL fill_msb_high got=%h want=0000", out_data_m[255:240]); end
    n_cmp++; if (out_data_m[15:0] !== 16'h000F) begin n_err++; $display("FAIL fill_msb_low got=%h want=000f", out_data_m[15:0]); end
    n_cmp++; if (out_data !== m_od_l) begin n_err++; $display("FAIL fill_word got=%h want=%h", out_data, m_od_l); end
    step(0, 0, 16'h0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_pulse_end got=%b want=0", out_valid); end
    n_cmp++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL fill_word_cnt got=%0d want=1", word_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0]  bp [48];
    logic [255:0] ew;
    logic [15:0]  wc0;
    int idx, w, cyc;
    for (int i = 0; i < 48; i++) bp[i] = 16'($urandom);
    wc0 = m_wc; idx = 0; w = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, 1, bp[idx < 48 ? idx : 47], 0, 0);
      if (last_acc) idx++;
    end
    for (int k = 0; k < 16; k++) ew[k*16 +: 16] = bp[k];
    n_cmp++; if (idx !== 32) begin n_err++; $display("FAIL bp_accepted got=%0d want=32", idx); end
    n_cmp++; if (obs_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", obs_in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ew) begin n_err++; $display("FAIL bp_held_word v=%b got=%h want=%h", out_valid, out_data, ew); end
    cyc = 0;
    while ((idx < 48 || out_valid) && cyc < 200) begin
      if (out_valid) begin
        for (int k = 0; k < 16; k++) ew[k*16 +: 16] = bp[(w < 3 ? w : 2)*16 + k];
        n_cmp++; if (out_data !== ew) begin n_err++; $display("FAIL bp_word%0d got=%h want=%h", w, out_data, ew); end
        w++;
      end
      step(0, idx < 48, bp[idx < 48 ? idx : 47], 0, 1);
      if (last_acc) idx++;
      n_cmp++; if (out_valid !== m_ov) begin n_err++; $display("FAIL bp_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_ov); end
      cyc++;
    end
    n_cmp++; if (cyc >= 200) begin n_err++; $display("FAIL bp_timeout cycles=%0d limit=200", cyc); end
    n_cmp++; if (w !== 3) begin n_err++; $display("FAIL bp_word_count got=%0d want=3", w); end
    n_cmp++; if (word_cnt !== 16'(wc0 + 16'd3)) begin n_err++; $display("FAIL bp_word_cnt got=%0d want=%0d", word_cnt, wc0 + 16'd3); end
  endtask

  task automatic test_flush();
    logic [15:0] wc0;
    wc0 = m_wc;
    for (int i = 0; i < 5; i++) step(0, 1, 16'hAAAA, 0, 1);
    step(0, 1, 16'hAAAA, 1, 1);
    n_cmp++; if (obs_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b want=0", obs_in_ready); end
    for (int i = 0; i < 16; i++) step(0, 1, 16'h5555, 0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== {16{16'h5555}}) begin n_err++; $display("FAIL flush_word v=%b got=%h", out_valid, out_data); end
    step(0, 0, 16'h0, 0, 1);
    n_cmp++; if (word_cnt !== 16'(wc0 + 16'd1)) begin n_err++; $display("FAIL flush_word_cnt got=%0d want=%0d", word_cnt, wc0 + 16'd1); end
  endtask

  task automatic test_flush_hold();
    logic [15:0] wc0;
    wc0 = m_wc;
    for (int i = 0; i < 32; i++) step(0, 1, 16'($urandom), 0, 0);
    step(0, 1, 16'h0BAD, 0, 0);
    n_cmp++; if (obs_in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL fh_hold rdy=%b v=%b want rdy=0 v=1", obs_in_ready, out_valid); end
    step(0, 1, 16'h0BAD, 1, 1);
    n_cmp++; if (word_cnt !== 16'(wc0 + 16'd1)) begin n_err++; $display("FAIL fh_word_cnt got=%0d want=%0d", word_cnt, wc0 + 16'd1); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fh_discard got=%b want=0", out_valid); end
    step(0, 0, 16'h0, 0, 1);
    n_cmp++; if (obs_in_ready !== 1'b1) begin n_err++; $display("FAIL fh_in_ready got=%b want=1", obs_in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fh_no_transfer got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] ew;
    logic [15:0]  s;
    for (int i = 0; i < 7; i++) step(0, 1, 16'hDEAD, 0, 1);
    step(1, 1, 16'hDEAD, 0, 1);
    n_cmp++; if (out_valid !== 1'b0 || word_cnt !== 16'h0) begin n_err++; $display("FAIL rm_reset v=%b cnt=%0d want v=0 cnt=0", out_valid, word_cnt); end
    for (int i = 0; i < 16; i++) begin
      s = 16'($urandom);
      ew[i*16 +: 16] = s;
      step(0, 1, s, 0, 1);
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ew) begin n_err++; $display("FAIL rm_word v=%b got=%h want=%h", out_valid, out_data, ew); end
    step(0, 0, 16'h0, 0, 1);
    n_cmp++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL rm_word_cnt got=%0d want=1", word_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 200) == 0, ($urandom % 4) != 0, 16'($urandom),
           ($urandom % 50) == 0, ($urandom % 3) != 0);
      n_cmp++; if (obs_in_ready !== exp_in_ready || obs_in_ready_m !== exp_in_ready) begin n_err++; $display("FAIL rnd_in_ready c=%0d got=%b/%b want=%b", c, obs_in_ready, obs_in_ready_m, exp_in_ready); end
      n_cmp++; if (out_valid !== m_ov || out_valid_m !== m_ov) begin n_err++; $display("FAIL rnd_out_valid c=%0d got=%b/%b want=%b", c, out_valid, out_valid_m, m_ov); end
      n_cmp++; if (out_data !== m_od_l) begin n_err++; $display("FAIL rnd_data_lsb c=%0d got=%h want=%h", c, out_data, m_od_l); end
      n_cmp++; if (out_data_m !== m_od_m) begin n_err++; $display("FAIL rnd_data_msb c=%0d got=%h want=%h", c, out_data_m, m_od_m); end
      n_cmp++; if (word_cnt !== m_wc || word_cnt_m !== m_wc) begin n_err++; $display("FAIL rnd_word_cnt c=%0d got=%0d/%0d want=%0d", c, word_cnt, word_cnt_m, m_wc); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    m_n = 0; m_held = 1'b0; m_ov = 1'b0; m_od_l = '0; m_od_m = '0; m_wc = '0;
    m_held_l = '0; m_held_m = '0;
    test_reset();
    test_fill();
    test_backpressure();
    test_flush();
    test_flush_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
